// File: rtl/himax_frame_grabber.sv
// Single-frame capture buffer for the Himax camera path: grab one frame (optional nibble packing
// and X/Y subsampling), then stream it out on a valid/ready byte port. Define HIMAX_GRAB_CHECKSUM_EN for a sum trailer.
module himax_frame_grabber #(
   parameter int PIX_W    = 8,
   parameter int MAX_COLS = 40,
   parameter int MAX_ROWS = 30,
   parameter int SUB_X    = 1,
   parameter int SUB_Y    = 1,
   parameter int DEPTH    = (MAX_COLS / SUB_X) * (MAX_ROWS / SUB_Y)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_grab,
   input  logic             i_fv,
   input  logic             i_lv,
   input  logic             i_pvalid,
   input  logic [PIX_W-1:0] i_pdata,
   output logic [7:0]       o_data,
   output logic             o_valid,
   input  logic             i_ready,
   output logic             o_busy,
   output logic             o_frame_done,
   output logic             o_overflow
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int XW = $clog2(MAX_COLS + 1);
   localparam int YW = $clog2(MAX_ROWS + 1);

   localparam logic [XW-1:0] COL_LIM = XW'(MAX_COLS);
   localparam logic [YW-1:0] ROW_LIM = YW'(MAX_ROWS);
   localparam logic [XW-1:0] SX      = XW'(SUB_X);
   localparam logic [YW-1:0] SY      = YW'(SUB_Y);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [1:0] {IDLE, WAIT_FRAME, CAPTURE, DUMP} state_t;

   state_t        state;
   logic          fv_d;
   logic          lv_d;
   logic          nib_phase;
   logic [3:0]    nib_hi;
   logic [XW-1:0] col;
   logic [YW-1:0] row;
   logic [CW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] rd_ptr;
   logic          rd_pend;
   logic          skid_valid;
   logic [7:0]    skid_data;

   logic [7:0]    mem [DEPTH];
   logic [7:0]    mem_q;

   logic [7:0]    pd8;
   logic          sample;
   logic          lv_rise;
   logic          lv_fall;
   logic          fv_fall;
   logic          eff_phase;
   logic          byte_ok;
   logic [7:0]    byte_val;
   logic          keep;
   logic          out_of_range;
   logic          full;
   logic          cap_byte;
   logic          wr_en;
   logic          cap_drop;
   logic          pop;
   logic          room;
   logic          items_left;
   logic          all_issued;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic          ck_issue;
   logic          dump_done;
   logic [7:0]    rd_byte;

`ifdef HIMAX_GRAB_CHECKSUM_EN
   logic          ck_issued;
   logic          ck_pend;
   logic [7:0]    csum;

   assign ck_issue = (state == DUMP) & room & ~items_left & ~ck_issued;
   assign rd_byte  = ck_pend ? csum : mem_q;
   assign all_issued = ~items_left & ck_issued;
`else
   assign ck_issue = 1'b0;
   assign rd_byte  = mem_q;
   assign all_issued = ~items_left;
`endif

   // Capture-side decode: nibble phase is forced to 0 on the cycle a line starts.
   always_comb begin
      pd8          = 8'(i_pdata);
      sample       = i_pvalid & i_fv & i_lv;
      lv_rise      = i_lv & ~lv_d;
      lv_fall      = ~i_lv & lv_d;
      fv_fall      = fv_d & ~i_fv;
      eff_phase    = nib_phase & ~lv_rise;
      byte_ok      = 1'b0;
      byte_val     = pd8;
      if (PIX_W == 4) begin
         byte_ok  = sample & eff_phase;
         byte_val = {nib_hi, pd8[3:0]};
      end else begin
         byte_ok  = sample;
         byte_val = pd8;
      end
      keep         = ((col % SX) == '0) && ((row % SY) == '0);
      out_of_range = (col >= COL_LIM) || (row >= ROW_LIM);
      full         = (wr_ptr >= DEPTH_C);
      cap_byte     = (state == CAPTURE) & byte_ok;
      wr_en        = cap_byte & ~out_of_range & keep & ~full;
      cap_drop     = cap_byte & (out_of_range | (keep & full));
   end

   // Dump-side flow control: a read may issue only if its data is guaranteed a slot
   // in the output or skid register one cycle later, even if the sink stalls.
   always_comb begin
      pop        = o_valid & i_ready;
      room       = ({1'b0, o_valid} + {1'b0, skid_valid} + {1'b0, rd_pend}) <= ({1'b0, pop} + 2'd1);
      items_left = (rd_ptr != count);
      rd_en      = 1'b0;
      rd_addr    = '0;
      if (state == DUMP) begin
         rd_en   = room & items_left;
         rd_addr = rd_ptr[AW-1:0];
      end else if (state == CAPTURE) begin
         rd_en   = fv_fall & (wr_ptr != '0);
      end
      dump_done  = (state == DUMP) & all_issued & ~rd_pend & ~skid_valid & (~o_valid | pop);
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr[AW-1:0]] <= byte_val;
      if (rd_en)
         mem_q <= mem[rd_addr];
   end

   // Main control FSM with registered status outputs and the output/skid pipeline.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         fv_d         <= 1'b1;
         lv_d         <= 1'b0;
         nib_phase    <= 1'b0;
         nib_hi       <= '0;
         col          <= '0;
         row          <= '0;
         wr_ptr       <= '0;
         count        <= '0;
         rd_ptr       <= '0;
         rd_pend      <= 1'b0;
         skid_valid   <= 1'b0;
         skid_data    <= '0;
         o_data       <= '0;
         o_valid      <= 1'b0;
         o_busy       <= 1'b0;
         o_frame_done <= 1'b0;
         o_overflow   <= 1'b0;
      end else begin
         fv_d         <= i_fv;
         lv_d         <= i_lv;
         o_frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (i_grab) begin
                  o_overflow <= 1'b0;
                  wr_ptr     <= '0;
                  o_busy     <= 1'b1;
                  state      <= WAIT_FRAME;
               end
            end
            WAIT_FRAME: begin
               if (~fv_d & i_fv) begin
                  col       <= '0;
                  row       <= '0;
                  nib_phase <= 1'b0;
                  state     <= CAPTURE;
               end
            end
            CAPTURE: begin
               if (fv_fall) begin
                  count      <= wr_ptr;
                  rd_ptr     <= (wr_ptr != '0) ? CW'(1) : '0;
                  rd_pend    <= (wr_ptr != '0);
                  skid_valid <= 1'b0;
                  o_valid    <= 1'b0;
                  state      <= DUMP;
               end else begin
                  if (lv_fall) begin
                     col <= '0;
                     if (row != ROW_LIM)
                        row <= row + 1'b1;
                  end
                  if (sample) begin
                     nib_phase <= (PIX_W == 4) ? ~eff_phase : 1'b0;
                     if (!eff_phase)
                        nib_hi <= pd8[3:0];
                  end else if (lv_rise) begin
                     nib_phase <= 1'b0;
                  end
                  if (byte_ok && (col != COL_LIM))
                     col <= col + 1'b1;
                  if (wr_en)
                     wr_ptr <= wr_ptr + 1'b1;
                  if (cap_drop)
                     o_overflow <= 1'b1;
               end
            end
            DUMP: begin
               if (rd_en)
                  rd_ptr <= rd_ptr + 1'b1;
               rd_pend <= rd_en | ck_issue;
               if (~o_valid | pop) begin
                  if (skid_valid) begin
                     o_valid    <= 1'b1;
                     o_data     <= skid_data;
                     skid_valid <= rd_pend;
                     skid_data  <= rd_byte;
                  end else if (rd_pend) begin
                     o_valid <= 1'b1;
                     o_data  <= rd_byte;
                  end else begin
                     o_valid <= 1'b0;
                  end
               end else if (rd_pend) begin
                  skid_valid <= 1'b1;
                  skid_data  <= rd_byte;
               end
               if (dump_done) begin
                  o_busy       <= 1'b0;
                  o_frame_done <= 1'b1;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef HIMAX_GRAB_CHECKSUM_EN
   // Trailer sum accumulates each buffer byte as it leaves the memory.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ck_issued <= 1'b0;
         ck_pend   <= 1'b0;
         csum      <= '0;
      end else if ((state == CAPTURE) && fv_fall) begin
         ck_issued <= 1'b0;
         ck_pend   <= 1'b0;
         csum      <= '0;
      end else if (state == DUMP) begin
         ck_pend <= ck_issue;
         if (ck_issue)
            ck_issued <= 1'b1;
         if (rd_pend && !ck_pend)
            csum <= csum + mem_q;
      end
   end
`endif

endmodule

// File: tb/tb_himax_frame_grabber.sv
// Scoreboard bench for himax_frame_grabber: byte-mode instance (default params) and a
// nibble/subsampling instance; stimulus pushes expected bytes, per-DUT monitors pop and compare.
module tb_himax_frame_grabber;

   logic       clk = 1'b0;
   logic       rst;
   logic       i_ready;

   logic       a_grab, a_fv, a_lv, a_pvalid;
   logic [7:0] a_pdata;
   logic [7:0] a_data;
   logic       a_valid, a_busy, a_done, a_ovf;

   logic       b_grab, b_fv, b_lv, b_pvalid;
   logic [3:0] b_pdata;
   logic [7:0] b_data;
   logic       b_valid, b_busy, b_done, b_ovf;

   int         checks_total  = 0;
   int         checks_passed = 0;
   logic [7:0] exp_a[$];
   logic [7:0] exp_b[$];
   int         done_cnt_a = 0;
   int         done_cnt_b = 0;
   int         ready_mode = 0;

   always #5 clk = ~clk;

   himax_frame_grabber dut_a (
      .clk(clk), .rst(rst), .i_grab(a_grab), .i_fv(a_fv), .i_lv(a_lv),
      .i_pvalid(a_pvalid), .i_pdata(a_pdata), .o_data(a_data), .o_valid(a_valid),
      .i_ready(i_ready), .o_busy(a_busy), .o_frame_done(a_done), .o_overflow(a_ovf)
   );

   himax_frame_grabber #(.PIX_W(4), .MAX_COLS(8), .MAX_ROWS(4), .SUB_X(2), .SUB_Y(2)) dut_b (
      .clk(clk), .rst(rst), .i_grab(b_grab), .i_fv(b_fv), .i_lv(b_lv),
      .i_pvalid(b_pvalid), .i_pdata(b_pdata), .o_data(b_data), .o_valid(b_valid),
      .i_ready(i_ready), .o_busy(b_busy), .o_frame_done(b_done), .o_overflow(b_ovf)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks_total++;
      if (actual === expected)
         checks_passed++;
      else
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Sink ready: 0 = always high, 1 = random, 2 = held low.
   initial begin
      i_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (ready_mode == 1)
            i_ready = 1'($urandom_range(0, 1));
         else
            i_ready = (ready_mode == 0);
      end
   end

   // Monitor for the byte-mode instance.
   bit         a_hold = 0;
   logic [7:0] a_hold_data = '0;
   bit         a_end_pending = 0;
   always @(negedge clk) begin
      if (rst) begin
         a_hold = 0;
         a_end_pending = 0;
      end else begin
         if (a_end_pending) begin
            checkOutput("A done/busy after last byte", {a_done, a_busy}, 2'b10);
            a_end_pending = 0;
         end
         if (a_hold)
            checkOutput("A stall hold", {a_valid, a_data}, {1'b1, a_hold_data});
         if (a_done) begin
            done_cnt_a++;
            checkOutput("A queue empty at done", exp_a.size(), 0);
         end
         if (a_valid && i_ready) begin
            if (exp_a.size() == 0) begin
               checks_total++;
               $display("[TB] FAIL A extra byte: got 0x%0h, expected no byte", a_data);
            end else begin
               checkOutput("A byte", a_data, exp_a.pop_front());
               if (exp_a.size() == 0)
                  a_end_pending = 1;
            end
         end
         a_hold = a_valid && !i_ready;
         a_hold_data = a_data;
      end
   end

   // Monitor for the nibble/subsampling instance.
   bit         b_hold = 0;
   logic [7:0] b_hold_data = '0;
   bit         b_end_pending = 0;
   always @(negedge clk) begin
      if (rst) begin
         b_hold = 0;
         b_end_pending = 0;
      end else begin
         if (b_end_pending) begin
            checkOutput("B done/busy after last byte", {b_done, b_busy}, 2'b10);
            b_end_pending = 0;
         end
         if (b_hold)
            checkOutput("B stall hold", {b_valid, b_data}, {1'b1, b_hold_data});
         if (b_done) begin
            done_cnt_b++;
            checkOutput("B queue empty at done", exp_b.size(), 0);
         end
         if (b_valid && i_ready) begin
            if (exp_b.size() == 0) begin
               checks_total++;
               $display("[TB] FAIL B extra byte: got 0x%0h, expected no byte", b_data);
            end else begin
               checkOutput("B byte", b_data, exp_b.pop_front());
               if (exp_b.size() == 0)
                  b_end_pending = 1;
            end
         end
         b_hold = b_valid && !i_ready;
         b_hold_data = b_data;
      end
   end

   task automatic grabA();
      a_grab = 1'b1;
      step();
      a_grab = 1'b0;
      checkOutput("A busy after grab", a_busy, 1);
      checkOutput("A overflow cleared by grab", a_ovf, 0);
   endtask

   task automatic grabB();
      b_grab = 1'b1;
      step();
      b_grab = 1'b0;
      checkOutput("B busy after grab", b_busy, 1);
      checkOutput("B overflow cleared by grab", b_ovf, 0);
   endtask

   // Byte-mode frame: pixel = r*cols + c; capture=1 pushes the bytes that fit 40x30.
   task automatic applyStimulus(input int cols, input int rows, input bit capture,
                                input int grab_row, input int gap);
      int sum = 0;
      int nbytes = 0;
      a_fv = 1'b1;
      step();
      step();
      for (int r = 0; r < rows; r++) begin
         if (r == grab_row) begin
            a_grab = 1'b1;
            step();
            a_grab = 1'b0;
         end
         a_lv = 1'b1;
         for (int c = 0; c < cols; c++) begin
            if (gap != 0 && (c % gap) == gap - 1) begin
               a_pvalid = 1'b0;
               step();
            end
            a_pvalid = 1'b1;
            a_pdata  = 8'(r * cols + c);
            if (capture && r < 30 && c < 40) begin
               exp_a.push_back(a_pdata);
               sum += a_pdata;
               nbytes++;
            end
            step();
         end
         a_pvalid = 1'b0;
         a_lv     = 1'b0;
         step();
         step();
      end
`ifdef HIMAX_GRAB_CHECKSUM_EN
      if (capture)
         exp_a.push_back(8'(sum));
`endif
      a_fv = 1'b0;
      step();
      if (capture && nbytes > 0) begin
         checkOutput("A no valid one cycle after fv fall", a_valid, 0);
         step();
         checkOutput("A first valid two cycles after fv fall", a_valid, 1);
      end
   endtask

   // Nibble-mode frame: nibble k of row r = (k + 3r) mod 16; keeps even bytes of even rows.
   task automatic applyStimulusNibble(input int nibs, input int rows);
      int sum = 0;
      for (int r = 0; r < rows; r++)
         for (int c = 0; 2 * c + 1 < nibs; c++)
            if (r < 4 && (r % 2) == 0 && c < 8 && (c % 2) == 0) begin
               exp_b.push_back({4'(2 * c + 3 * r), 4'(2 * c + 1 + 3 * r)});
               sum += {4'(2 * c + 3 * r), 4'(2 * c + 1 + 3 * r)};
            end
`ifdef HIMAX_GRAB_CHECKSUM_EN
      exp_b.push_back(8'(sum));
`endif
      b_fv = 1'b1;
      step();
      step();
      for (int r = 0; r < rows; r++) begin
         b_lv = 1'b1;
         for (int k = 0; k < nibs; k++) begin
            b_pvalid = 1'b1;
            b_pdata  = 4'(k + 3 * r);
            step();
         end
         b_pvalid = 1'b0;
         b_lv     = 1'b0;
         step();
         step();
      end
      b_fv = 1'b0;
      step();
   endtask

   task automatic waitDone(input bit which, input int start);
      int n = 0;
      while ((which ? done_cnt_b : done_cnt_a) == start && n < 6000) begin
         step();
         n++;
      end
      checkOutput(which ? "B frame_done seen" : "A frame_done seen",
                  which ? done_cnt_b : done_cnt_a, start + 1);
      repeat (3) step();
      checkOutput(which ? "B single done pulse" : "A single done pulse",
                  which ? done_cnt_b : done_cnt_a, start + 1);
      checkOutput(which ? "B queue drained" : "A queue drained",
                  which ? exp_b.size() : exp_a.size(), 0);
   endtask

   initial begin
      int start;
      rst = 1'b1;
      a_grab = 0; a_fv = 0; a_lv = 0; a_pvalid = 0; a_pdata = '0;
      b_grab = 0; b_fv = 0; b_lv = 0; b_pvalid = 0; b_pdata = '0;
      repeat (3) step();
      checkOutput("A reset outputs", {a_data, a_valid, a_busy, a_done, a_ovf}, 12'h000);
      checkOutput("B reset outputs", {b_data, b_valid, b_busy, b_done, b_ovf}, 12'h000);
      rst = 1'b0;
      repeat (3) step();

      for (int f = 0; f < 2; f++) begin
         start = done_cnt_a;
         grabA();
         applyStimulus(40, 30, 1'b1, -1, 0);
         waitDone(1'b0, start);
         checkOutput("A overflow clear on full frame", a_ovf, 0);
      end

      start = done_cnt_a;
      applyStimulus(40, 30, 1'b0, 12, 0);
      applyStimulus(40, 30, 1'b1, -1, 0);
      waitDone(1'b0, start);

      ready_mode = 1;
      start = done_cnt_a;
      grabA();
      applyStimulus(40, 30, 1'b1, -1, 3);
      waitDone(1'b0, start);
      ready_mode = 0;

      start = done_cnt_a;
      grabA();
      applyStimulus(41, 30, 1'b1, -1, 0);
      waitDone(1'b0, start);
      checkOutput("A overflow on 41 columns", a_ovf, 1);

      start = done_cnt_a;
      grabA();
      applyStimulus(40, 31, 1'b1, -1, 0);
      waitDone(1'b0, start);
      checkOutput("A overflow on 31 rows", a_ovf, 1);

      start = done_cnt_a;
      grabA();
      applyStimulus(40, 0, 1'b1, -1, 0);
      waitDone(1'b0, start);
      checkOutput("A overflow clear on empty frame", a_ovf, 0);

      ready_mode = 2;
      grabA();
      applyStimulus(8, 4, 1'b1, -1, 0);
      repeat (4) step();
      checkOutput("A stalled head byte", {a_valid, a_data}, {1'b1, exp_a[0]});
      rst = 1'b1;
      step();
      checkOutput("A outputs after mid-dump reset", {a_data, a_valid, a_busy, a_done, a_ovf}, 12'h000);
      exp_a.delete();
      rst = 1'b0;
      ready_mode = 0;
      repeat (2) step();
      start = done_cnt_a;
      grabA();
      applyStimulus(5, 3, 1'b1, -1, 0);
      waitDone(1'b0, start);

      start = done_cnt_b;
      grabB();
      applyStimulusNibble(17, 4);
      waitDone(1'b1, start);
      checkOutput("B overflow clear with odd nibble", b_ovf, 0);

      start = done_cnt_b;
      grabB();
      applyStimulusNibble(20, 4);
      waitDone(1'b1, start);
      checkOutput("B overflow on wide line", b_ovf, 1);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule

// File: doc/himax_frame_grabber.md
# himax_frame_grabber

Parametrised single-frame capture buffer for the Himax camera path. It replaces the fixed-size grab-and-dump logic of the blink design. On a one-cycle grab request it waits for the next frame start and captures one frame, optionally packing 4-bit nibbles and subsampling in X/Y. It then streams the buffered bytes out on a valid/ready byte interface, normally into the UART transmitter. It sits between the (already clk-domain) pixel interface and the host UART.

## Interface
Parameters:
- PIX_W, 8: sensor data width; legal values 4 (nibble mode, high nibble first) or 8.
- MAX_COLS, 40: maximum bytes per line after packing.
- MAX_ROWS, 30: maximum lines per frame.
- SUB_X, 1: keep every SUB_X-th byte of a line; legal values 1, 2, 4.
- SUB_Y, 1: keep every SUB_Y-th line; legal values 1, 2, 4.
- DEPTH, (MAX_COLS/SUB_X)*(MAX_ROWS/SUB_Y): buffer size in bytes; derived, do not override.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- i_grab  in  1  capture request pulse.
- i_fv  in  1  frame valid.
- i_lv  in  1  line valid.
- i_pvalid  in  1  pixel strobe, one per sensor sample.
- i_pdata  in  PIX_W  pixel data.
- o_data  out  8  output byte.
- o_valid  out  1  output byte valid.
- i_ready  in  1  downstream accepts byte.
- o_busy  out  1  high in any state other than IDLE.
- o_frame_done  out  1  one-cycle pulse at end of dump.
- o_overflow  out  1  sticky; cleared on accepted i_grab.

## Operation
- States: IDLE, WAIT_FRAME, CAPTURE, DUMP.
- IDLE: on i_grab, clear o_overflow, clear write pointer, go to WAIT_FRAME. i_grab in any other state is ignored.
- WAIT_FRAME: go to CAPTURE on a rising edge of i_fv, i.e. fv_d=0 and i_fv=1.
  - fv_d resets to 1, so a frame already in progress at reset or at grab time is skipped.
  - Samples in the rise cycle are not captured.
- CAPTURE: a sample is taken when i_pvalid & i_fv & i_lv.
  - PIX_W=4: a nibble phase toggles per sample. Phase 0 latches bits [7:4]; phase 1 forms the byte. The phase clears on each i_lv rising edge, and an odd trailing nibble is discarded.
  - PIX_W=8: each sample is one byte.
  - A byte column counter increments per byte and clears on i_lv falling edge. The row counter increments on i_lv falling edge.
  - A byte is written when col%SUB_X==0 and row%SUB_Y==0.
  - A byte is dropped and o_overflow set when col>=MAX_COLS, row>=MAX_ROWS, or the pointer has reached DEPTH.
  - i_fv falling edge: latch count = bytes written, go to DUMP.
- DUMP: present buffer bytes 0..count-1 in order, then go to IDLE with an o_frame_done pulse.
  - count=0: no bytes are emitted (checksum byte only, if enabled).
- Pixel inputs are ignored outside CAPTURE. Buffer contents persist until overwritten.

## Timing
- Reset values: o_data=0, o_valid=0, o_busy=0, o_frame_done=0, o_overflow=0; state IDLE; counters 0; fv_d=1.
- i_grab accepted at cycle N: o_busy=1 at N+1.
- i_fv falling sampled at cycle N: state DUMP at N+1; first o_valid at N+2. Buffer read latency is 1 cycle, modelled as inferred EBR.
- Handshake: a byte transfers when o_valid & i_ready.
  - While o_valid & ~i_ready, o_data is held stable.
  - o_valid never drops without a transfer.
- Throughput: sustained 1 byte/cycle with i_ready held high, using a prefetch/skid register.
- Last transfer at cycle M: o_frame_done=1 and o_busy=0 at M+1. An i_grab at M+1 is accepted.
- Reset mid-operation: immediate return to reset values; any partial dump is abandoned.

## Configuration
- HIMAX_GRAB_CHECKSUM_EN defined: after the last buffer byte, one extra byte is emitted, equal to the mod-256 sum of all emitted buffer bytes. It follows the same handshake, and o_frame_done follows its transfer.
- HIMAX_GRAB_CHECKSUM_EN undefined: no trailer, and no adder logic is synthesised.

## Test plan
- Default params, 40x30 frame of incrementing bytes: exactly 1200 bytes 0x00..0xFF then 0x00..0xAF, in order. o_frame_done pulses once and o_overflow=0. Repeat twice back-to-back.
- PIX_W=4, nibbles 0x0,0x1,...,0xF repeating: bytes 0x01,0x23,...,0xEF. With 80 nibbles per line, 40 bytes per line.
- SUB_X=2, SUB_Y=2, 40x30 frame with pixel = col + 40·row: 300 bytes. Line 0 is 0,2,4,..., and the next kept line starts at 80.
- i_grab while i_fv is high mid-frame: that frame produces no bytes. The next frame is captured in full (1200 bytes).
- Random i_ready backpressure (about 50%) during dump: no byte lost or duplicated, and o_data is stable while stalled. With checksum enabled, the trailer equals the sum of the emitted buffer bytes mod 256.
- 41-byte lines or 31 lines: o_overflow=1, extra bytes are dropped, and exactly 1200 bytes are emitted. A new i_grab clears o_overflow.
